// File: rtl/mvu_xnor_fold_ctrl.sv
// Fold sequencer for the XNOR matrix-vector stream unit.
// Walks SF/NF folds, issues buffer/weight addresses and accumulator tags.
module mvu_xnor_fold_ctrl #(
  parameter int SF      = 4,
  parameter int NF      = 2,
  parameter int ACC_LAT = 2,
  parameter int SFW     = (SF > 1) ? $clog2(SF) : 1,
  parameter int WAW     = (SF * NF > 1) ? $clog2(SF * NF) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_v,
  output logic           in_rdy,
  input  logic           out_rdy,
  output logic           out_v,
  output logic           do_mvau_stream,
  output logic           act_sel,
  output logic           ibuf_we,
  output logic [SFW-1:0] ibuf_addr,
  output logic [WAW-1:0] wmem_addr,
  output logic           acc_en,
  output logic           acc_ld
);

  localparam int NFW   = (NF > 1) ? $clog2(NF) : 1;
  localparam int DEPTH = ACC_LAT + 1;

  typedef enum logic {
    FILL,
    REUSE
  } state_e;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

  state_e         state_q, state_d;
  logic [SFW-1:0] sf_cnt_q, sf_cnt_d;
  logic [NFW-1:0] nf_cnt_q, nf_cnt_d;
  tag_t           tag_q [1:DEPTH];
  tag_t           tag_d [1:DEPTH];

  logic stall;
  logic pipe_en;
  logic beat;
  logic sf_last;
  logic nf_last;
  tag_t new_tag;

  assign sf_last = (sf_cnt_q == SFW'(SF - 1));
  assign nf_last = (nf_cnt_q == NFW'(NF - 1));

  assign out_v  = tag_q[DEPTH].valid & tag_q[DEPTH].last;
  assign acc_en = tag_q[ACC_LAT].valid;
  assign acc_ld = tag_q[ACC_LAT].valid & tag_q[ACC_LAT].first;

  // A held result freezes counters and the whole tag pipeline.
  assign stall          = out_v & ~out_rdy;
  assign pipe_en        = ~stall;
  assign do_mvau_stream = pipe_en;

  assign ibuf_addr = sf_cnt_q;
  assign wmem_addr = WAW'(nf_cnt_q) * WAW'(SF) + WAW'(sf_cnt_q);

  always_comb begin
    state_d  = state_q;
    sf_cnt_d = sf_cnt_q;
    nf_cnt_d = nf_cnt_q;
    in_rdy   = 1'b0;
    act_sel  = 1'b0;
    beat     = 1'b0;
    unique case (state_q)
      FILL: begin
        in_rdy = pipe_en;
        beat   = pipe_en & in_v;
      end
      REUSE: begin
        act_sel = 1'b1;
        beat    = pipe_en;
      end
      default: ;
    endcase
    if (beat) begin
      if (sf_last) begin
        sf_cnt_d = '0;
        if (nf_last) nf_cnt_d = '0;
        else         nf_cnt_d = nf_cnt_q + 1'b1;
      end else begin
        sf_cnt_d = sf_cnt_q + 1'b1;
      end
    end
    state_d = (nf_cnt_d == '0) ? FILL : REUSE;
  end

  assign ibuf_we = beat & ~act_sel;

  always_comb begin
    new_tag.valid = beat;
    new_tag.first = beat & (sf_cnt_q == '0);
    new_tag.last  = beat & sf_last;
  end

  always_comb begin
    for (int i = 1; i <= DEPTH; i++) tag_d[i] = tag_q[i];
    if (pipe_en) begin
      tag_d[1] = new_tag;
      for (int i = 2; i <= DEPTH; i++) tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= FILL;
      sf_cnt_q <= '0;
      nf_cnt_q <= '0;
      for (int i = 1; i <= DEPTH; i++) tag_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      sf_cnt_q <= sf_cnt_d;
      nf_cnt_q <= nf_cnt_d;
      for (int i = 1; i <= DEPTH; i++) tag_q[i] <= tag_d[i];
    end
  end

endmodule

// File: tb/tb_mvu_xnor_fold_ctrl.sv
// Bench for mvu_xnor_fold_ctrl: vector table, scoreboard monitor,
// hand sequences for stall, reset, wrap and the SF=1/NF=1 build.
module tb_mvu_xnor_fold_ctrl;

  localparam int SF      = 4;
  localparam int NF      = 2;
  localparam int ACC_LAT = 2;

  logic clk;
  logic rst_n;
  logic in_v;
  logic out_rdy;

  logic       a_in_rdy, a_out_v, a_do, a_act_sel, a_ibuf_we;
  logic       a_acc_en, a_acc_ld;
  logic [1:0] a_ibuf_addr;
  logic [2:0] a_wmem_addr;

  logic b_in_v;
  logic b_out_rdy;
  logic b_in_rdy, b_out_v, b_do, b_act_sel, b_ibuf_we;
  logic b_acc_en, b_acc_ld;
  logic [0:0] b_ibuf_addr;
  logic [0:0] b_wmem_addr;

  mvu_xnor_fold_ctrl #(.SF(SF), .NF(NF), .ACC_LAT(ACC_LAT)) u_a (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_v           (in_v),
    .in_rdy         (a_in_rdy),
    .out_rdy        (out_rdy),
    .out_v          (a_out_v),
    .do_mvau_stream (a_do),
    .act_sel        (a_act_sel),
    .ibuf_we        (a_ibuf_we),
    .ibuf_addr      (a_ibuf_addr),
    .wmem_addr      (a_wmem_addr),
    .acc_en         (a_acc_en),
    .acc_ld         (a_acc_ld)
  );

  mvu_xnor_fold_ctrl #(.SF(1), .NF(1), .ACC_LAT(2)) u_b (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_v           (b_in_v),
    .in_rdy         (b_in_rdy),
    .out_rdy        (b_out_rdy),
    .out_v          (b_out_v),
    .do_mvau_stream (b_do),
    .act_sel        (b_act_sel),
    .ibuf_we        (b_ibuf_we),
    .ibuf_addr      (b_ibuf_addr),
    .wmem_addr      (b_wmem_addr),
    .acc_en         (b_acc_en),
    .acc_ld         (b_acc_ld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic iv, input logic ordy,
                      input logic biv = 1'b0);
    @(posedge clk);
    #1;
    rst_n   = r;
    in_v    = iv;
    out_rdy = ordy;
    b_in_v  = biv;
    @(negedge clk);
  endtask

  logic [11:0] act_vec;
  assign act_vec = {a_in_rdy, a_do, a_act_sel, a_ibuf_we, a_acc_en,
                    a_acc_ld, a_out_v, a_ibuf_addr, a_wmem_addr};

  // Scoreboard: result and accumulator tags keyed by enabled-cycle count.
  typedef struct {
    int unsigned e;
    bit          first;
  } at_t;

  bit          mon_on = 0;
  int unsigned en_cnt = 0;
  int unsigned oq[$];
  at_t         aq[$];
  int          k = 0;
  int          out_hs = 0;
  bit          m_ov, m_en, m_reuse, m_beat, m_ae, m_al;
  logic [11:0] m_exp;

  always @(negedge clk) begin
    if (mon_on) begin
      m_ov    = (oq.size() > 0) && (en_cnt - oq[0] == ACC_LAT + 1);
      m_en    = !(m_ov && !out_rdy);
      m_reuse = (k % (SF * NF)) >= SF;
      m_beat  = m_en && (m_reuse || in_v);
      m_ae    = (aq.size() > 0) && (en_cnt - aq[0].e == ACC_LAT);
      m_al    = m_ae && aq[0].first;
      m_exp   = {m_en && !m_reuse, m_en, m_reuse, m_beat && !m_reuse,
                 m_ae, m_al, m_ov, 2'(k % SF), 3'(k % (SF * NF))};
      chk("monitor", act_vec, m_exp);
      if (a_out_v && out_rdy) out_hs++;
      if (!rst_n) begin
        oq.delete();
        aq.delete();
        k = 0;
      end else begin
        if (m_ov && out_rdy) void'(oq.pop_front());
        if (m_en && m_ae) void'(aq.pop_front());
        if (m_beat) begin
          aq.push_back('{e: en_cnt, first: (k % SF) == 0});
          if ((k % SF) == SF - 1) oq.push_back(en_cnt);
          k++;
        end
      end
      if (m_en) en_cnt++;
    end
  end

  typedef struct {
    logic       in_v;
    logic       out_rdy;
    logic [2:0] wmem;
    logic       in_rdy;
    logic       ibuf_we;
    logic       act_sel;
    logic       acc_en;
    logic       acc_ld;
    logic       out_v;
  } vec_t;

  vec_t       tbl[12];
  int         first_ov;
  logic [8:0] ld_seen;
  logic       ov_seen;
  int         accepted;
  int         cyc;
  logic [9:0] pat;
  logic [15:0] hb;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1, 1, 3'd0, 1, 1, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 3'd1, 1, 1, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 3'd2, 1, 1, 0, 1, 1, 0};
    tbl[3]  = '{1, 1, 3'd3, 1, 1, 0, 1, 0, 0};
    tbl[4]  = '{1, 1, 3'd4, 0, 0, 1, 1, 0, 0};
    tbl[5]  = '{1, 1, 3'd5, 0, 0, 1, 1, 0, 0};
    tbl[6]  = '{1, 1, 3'd6, 0, 0, 1, 1, 1, 1};
    tbl[7]  = '{1, 1, 3'd7, 0, 0, 1, 1, 0, 0};
    tbl[8]  = '{1, 1, 3'd0, 1, 1, 0, 1, 0, 0};
    tbl[9]  = '{1, 1, 3'd1, 1, 1, 0, 1, 0, 0};
    tbl[10] = '{1, 1, 3'd2, 1, 1, 0, 1, 1, 1};
    tbl[11] = '{1, 1, 3'd3, 1, 1, 0, 1, 0, 0};

    rst_n     = 1'b0;
    in_v      = 1'b0;
    out_rdy   = 1'b1;
    b_in_v    = 1'b0;
    b_out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mon_on = 1;
    @(negedge clk);
    chk("reset", act_vec, 12'b1100_0000_0000);

    // Full vector with live input then replay.
    for (int i = 0; i < 12; i++) begin
      step(1'b1, tbl[i].in_v, tbl[i].out_rdy);
      chk($sformatf("vec%0d", i),
          {a_wmem_addr, a_in_rdy, a_ibuf_we, a_act_sel,
           a_acc_en, a_acc_ld, a_out_v},
          {tbl[i].wmem, tbl[i].in_rdy, tbl[i].ibuf_we, tbl[i].act_sel,
           tbl[i].acc_en, tbl[i].acc_ld, tbl[i].out_v});
    end

    // Toggling in_v.
    step(1'b0, 1'b0, 1'b1);
    first_ov = -1;
    ld_seen  = '0;
    for (int c = 0; c < 16; c++) begin
      step(1'b1, (c < 8) ? ((c % 2) == 0) : 1'b0, 1'b1);
      if (c < 9) ld_seen[c] = a_acc_ld;
      if (a_out_v && first_ov < 0) first_ov = c;
    end
    chk("toggle_acc_ld", 32'(ld_seen), 32'h004);
    chk("toggle_out_v_cycle", 32'(first_ov), 32'd9);

    // Downstream stall during fill of the second vector.
    step(1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 16; c++) begin
      step(1'b1, 1'b1, !(c >= 10 && c <= 12));
      if (c >= 10 && c <= 12)
        chk($sformatf("stall_c%0d", c),
            {a_out_v, a_wmem_addr, a_in_rdy, a_do, a_ibuf_we},
            {1'b1, 3'd2, 1'b0, 1'b0, 1'b0});
      if (c == 13)
        chk("stall_resume", {a_wmem_addr, a_ibuf_we, a_out_v},
            {3'd2, 1'b1, 1'b1});
      if (c == 14)
        chk("stall_next", {a_wmem_addr, a_ibuf_we, a_out_v},
            {3'd3, 1'b1, 1'b0});
    end

    // Reset during replay at sf=2.
    step(1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 6; c++) step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("rst_pre", {a_wmem_addr, a_act_sel}, {3'd6, 1'b1});
    ov_seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 1'b0, 1'b1);
      if (c == 0)
        chk("rst_post", {a_in_rdy, a_act_sel, a_wmem_addr},
            {1'b1, 1'b0, 3'd0});
      ov_seen = ov_seen | a_out_v;
    end
    chk("rst_no_out_v", 32'(ov_seen), 32'd0);

    // Three full vectors under random input and backpressure.
    step(1'b0, 1'b0, 1'b1);
    out_hs   = 0;
    accepted = 0;
    cyc      = 0;
    while (accepted < 12 && cyc < 2000) begin
      step(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      if (in_v && a_in_rdy) accepted++;
      cyc++;
    end
    chk("wrap_accepted", 32'(accepted), 32'd12);
    repeat (20) step(1'b1, 1'b0, 1'b1);
    chk("wrap_counters", {a_wmem_addr, a_ibuf_addr, a_act_sel, a_in_rdy},
        {3'd0, 2'd0, 1'b0, 1'b1});
    chk("wrap_out_hs", 32'(out_hs), 32'd6);

    // SF=1, NF=1 build: load at +2, result at +3.
    pat = 10'b00_1011_1001;
    hb  = '0;
    for (int c = 0; c < 16; c++) begin
      step(1'b1, 1'b0, 1'b1, (c < 10) ? pat[c] : 1'b0);
      hb[c] = b_in_v;
      chk($sformatf("sf1_c%0d", c),
          {b_acc_ld, b_out_v, b_act_sel, b_in_rdy, b_wmem_addr},
          {(c >= 2) ? hb[(c >= 2) ? c - 2 : 0] : 1'b0,
           (c >= 3) ? hb[(c >= 3) ? c - 3 : 0] : 1'b0,
           1'b0, 1'b1, 1'b0});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
